// File: rtl/midi_rx.sv
// MIDI receiver: 8N1 UART front end feeding a channel-filtered Note On/Off parser
// that maintains a one-hot-per-key held-note bitmap.
module midi_rx #(
    parameter int CLK_HZ   = 100000000,
    parameter int BAUD     = 31250,
    parameter int NUM_KEYS = 10,
    parameter int BASE_KEY = 60,
    parameter int CHANNEL  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [NUM_KEYS-1:0] note,
    output logic                key_valid,
    output logic [6:0]          key,
    output logic [6:0]          velocity,
    output logic                key_on,
    output logic                frame_err
);
    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_nx;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          half_done, bit_done;
    logic          byte_ready, ferr, sample;

    // Synchronizer flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign half_done = (cnt == CW'(HALF - 1));
    assign bit_done  = (cnt == CW'(CPB - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!rx_s) state_nx = START;
            START:     if (half_done) state_nx = rx_s ? IDLE : DATA;
            DATA:      if (bit_done && bit_idx == 3'd7) state_nx = STOP;
            STOP:      if (bit_done) state_nx = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == STOP) && bit_done && rx_s;
        ferr       = (state == STOP) && bit_done && !rx_s;
        sample     = (state == DATA) && bit_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE || state == WAIT_HIGH || state != state_nx || bit_done)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == IDLE)
                bit_idx <= '0;
            else if (sample)
                bit_idx <= bit_idx + 1'b1;
            if (sample)
                shreg <= {rx_s, shreg[7:1]};
        end
    end

    // Parser: running status, data index and first data byte of the pending message.
    logic [7:0]          rs;
    logic                idx;
    logic [6:0]          d0;
    logic [7:0]          key8, koff;
    logic                in_range, voice, is_on;
    logic [NUM_KEYS-1:0] mask;

    localparam logic [7:0] BASE8 = 8'(BASE_KEY);
    localparam logic [7:0] END8  = 8'(BASE_KEY + NUM_KEYS);

    always_comb begin
        key8     = {1'b0, d0};
        koff     = key8 - BASE8;
        in_range = (key8 >= BASE8) && (key8 < END8);
        voice    = (rs[7:4] == 4'h8) || (rs[7:4] == 4'h9) || (rs[7:4] == 4'hB);
        is_on    = (rs[7:4] == 4'h9) && (shreg[6:0] != 7'd0);
        mask     = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            mask[i] = (koff == 8'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs        <= '0;
            idx       <= 1'b0;
            d0        <= '0;
            note      <= '0;
            key_valid <= 1'b0;
            key       <= '0;
            velocity  <= '0;
            key_on    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= ferr;
            if (byte_ready) begin
                if (shreg[7]) begin
                    if (shreg[7:3] == 5'b11111) begin
                        // realtime bytes pass through without touching parser state
                    end else if (shreg[7:4] == 4'hF) begin
                        rs <= '0;
                    end else begin
                        rs  <= (shreg[3:0] == 4'(CHANNEL)) ? shreg : 8'h00;
                        idx <= 1'b0;
                    end
                end else if (voice) begin
                    if (!idx) begin
                        d0  <= shreg[6:0];
                        idx <= 1'b1;
                    end else begin
                        idx <= 1'b0;
                        if (rs[7:4] == 4'hB) begin
                            if (d0 == 7'd123) note <= '0;
                        end else begin
                            key_valid <= 1'b1;
                            key       <= d0;
                            velocity  <= shreg[6:0];
                            key_on    <= is_on;
                            if (in_range)
                                note <= is_on ? (note | mask) : (note & ~mask);
                        end
                    end
                end
            end
        end
    end
endmodule
